// File: rtl/lcd_pixel_streamer.sv
// Frame scanner feeding coordinates into a fixed-latency paint chain and collecting
// the returned colours into a credit-protected FWFT FIFO towards the LCD writer.
module lcd_pixel_streamer #(
   parameter int SCREEN_W   = 480,
   parameter int SCREEN_H   = 800,
   parameter int PIPE_LAT   = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               frame_start,
   output logic               busy,
   output logic               frame_done,
   output logic signed [15:0] paint_x,
   output logic signed [15:0] paint_y,
   input  logic [15:0]        paint_color,
   output logic [15:0]        pix_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic               pix_last,
   output logic [1:0]         dbg_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [15:0] X_MAX   = 16'(SCREEN_W - 1);
   localparam logic [15:0] Y_MAX   = 16'(SCREEN_H - 1);
   localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [15:0]         x_q, x_d, y_q, y_d;
   logic [PIPE_LAT-1:0] issue_sr_q, issue_sr_d, last_sr_q, last_sr_d;
   logic [CW-1:0]       inflight_q, inflight_d, count_q, count_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                done_q, done_d;
   logic [16:0]         mem_q [FIFO_DEPTH];
   logic                issue, last_issue, push, pop;
   logic [CW:0]         occupancy;
   logic [16:0]         head;

   // Pixel stream: pix_data/pix_last are the FIFO head whenever pix_valid is high and
   // stay put until a cycle with pix_valid & pix_ready, which is the one transfer.
   assign head       = mem_q[rd_ptr_q];
   assign pix_valid  = (count_q != '0);
   assign pix_data   = pix_valid ? head[15:0] : '0;
   assign pix_last   = pix_valid & head[16];
   assign pop        = pix_valid & pix_ready;
   assign push       = issue_sr_q[PIPE_LAT-1];
   assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign paint_x    = $signed(x_q);
   assign paint_y    = $signed(y_q);
   assign dbg_state  = state_q;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      issue      = 1'b0;
      last_issue = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            x_d = '0;
            y_d = '0;
            if (frame_start) state_d = SCAN;
         end
         SCAN: begin
            // Issue only while every outstanding colour is guaranteed a FIFO slot.
            if (occupancy < DEPTH_L) begin
               issue = 1'b1;
               if (x_q == X_MAX) begin
                  if (y_q == Y_MAX) begin
                     last_issue = 1'b1;
                     state_d    = DRAIN;
                  end else begin
                     x_d = '0;
                     y_d = y_q + 16'd1;
                  end
               end else begin
                  x_d = x_q + 16'd1;
               end
            end
         end
         DRAIN: begin
            if (pop && pix_last && (inflight_q == '0) && (count_q == CW'(1))) begin
               state_d = IDLE;
               done_d  = 1'b1;
               x_d     = '0;
               y_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      issue_sr_d    = issue_sr_q << 1;
      issue_sr_d[0] = issue;
      last_sr_d     = last_sr_q << 1;
      last_sr_d[0]  = last_issue;
      inflight_d    = inflight_q + CW'(issue) - CW'(push);
      count_d       = count_q + CW'(push) - CW'(pop);
      wr_ptr_d      = wr_ptr_q + PW'(push);
      rd_ptr_d      = rd_ptr_q + PW'(pop);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         issue_sr_q <= '0;
         last_sr_q  <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         issue_sr_q <= issue_sr_d;
         last_sr_q  <= last_sr_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         done_q     <= done_d;
      end
   end

   // Storage needs no reset: outputs are gated by pix_valid, which derives from count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {last_sr_q[PIPE_LAT-1], paint_color};
   end

endmodule

// File: tb/tb_lcd_pixel_streamer.sv
// Bench for lcd_pixel_streamer on a 4x3 screen: painter model, in-order scoreboard,
// per-cycle stream checks and directed timing expectations.
module tb_lcd_pixel_streamer;
   localparam int W     = 4;
   localparam int H     = 3;
   localparam int LAT   = 5;
   localparam int DEPTH = 8;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               frame_start = 1'b0;
   logic               pix_ready = 1'b0;
   logic               busy, frame_done, pix_valid, pix_last;
   logic signed [15:0] paint_x, paint_y;
   logic [15:0]        paint_color, pix_data;
   logic [1:0]         dbg_state;

   int total = 0;
   int bad   = 0;

   logic [16:0] exp_q[$];
   logic [15:0] got_seq [64];
   logic [15:0] lit_seq [12] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd16, 16'd17,
                                 16'd18, 16'd19, 16'd32, 16'd33, 16'd34, 16'd35};
   logic [15:0] pnt_pipe [LAT];
   logic [16:0] sb_word, prev_word;
   logic        prev_stall = 1'b0;
   int          fx = 0;
   int          issued;

   lcd_pixel_streamer #(
      .SCREEN_W(W), .SCREEN_H(H), .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn), .frame_start(frame_start), .busy(busy),
      .frame_done(frame_done), .paint_x(paint_x), .paint_y(paint_y),
      .paint_color(paint_color), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_last(pix_last), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] color_of(input int x, input int y);
      return 16'(x + 16 * y);
   endfunction

   // Painter: colour of the coordinate shown LAT cycles earlier; noise while idle.
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pnt_pipe[i] <= pnt_pipe[i-1];
      pnt_pipe[0] <= busy ? color_of(int'(paint_x), int'(paint_y)) : 16'($urandom);
   end
   assign paint_color = pnt_pipe[LAT-1];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic expect_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            exp_q.push_back({1'((x == W - 1) && (y == H - 1)), color_of(x, y)});
   endtask

   function automatic logic rdy(input int mode, input int k);
      case (mode)
         1:       return !((k >= 5) && (k <= 30));
         2:       return 1'($urandom_range(0, 1));
         default: return 1'b1;
      endcase
   endfunction

   // Compare process: scoreboard order, stall stability, credit bound.
   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
         fx = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(pix_valid), 32'd1);
            check("stall_data", 32'({pix_last, pix_data}), 32'(prev_word));
         end
         if (busy) begin
            issued = int'(paint_y) * W + int'(paint_x);
            total++;
            if (issued - fx > DEPTH) begin
               bad++;
               $display("FAIL credit_bound: outstanding %0d exceeds %0d", issued - fx, DEPTH);
            end
         end else begin
            fx = 0;
         end
         if (pix_valid && pix_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_extra: got pixel %0d with nothing expected", pix_data);
            end else begin
               sb_word = exp_q.pop_front();
               if ({pix_last, pix_data} !== sb_word) begin
                  bad++;
                  $display("FAIL sb_pixel: got last=%0d data=%0d expected last=%0d data=%0d",
                           pix_last, pix_data, sb_word[16], sb_word[15:0]);
               end
            end
            fx++;
         end
         prev_stall = pix_valid && !pix_ready;
         prev_word  = {pix_last, pix_data};
      end
   end

   // Non-chained: call at the start of cycle 0. Chained: call at the negedge of the
   // frame_done cycle with frame_start already high.
   task automatic run_frame(input bit chained, input int mode,
                            output int fv, output int dc, output int nx, output int nl);
      fv = -1; dc = -1; nx = 0; nl = 0;
      if (!chained) begin
         frame_start = 1'b1;
         pix_ready   = rdy(mode, 0);
      end
      expect_frame();
      for (int k = 1; k <= 400; k++) begin
         @(posedge clk); #1;
         frame_start = (mode == 3) && ((k == 3) || (k == 15));
         pix_ready   = rdy(mode, k);
         @(negedge clk);
         if (k == 1) begin
            check("start_busy", 32'(busy), 32'd1);
            check("start_x", 32'(paint_x), 32'd0);
            check("start_y", 32'(paint_y), 32'd0);
         end
         if ((mode == 1) && (k == 30)) begin
            check("bp_hold_x", 32'(paint_x), 32'd0);
            check("bp_hold_y", 32'(paint_y), 32'd2);
            check("bp_no_xfer", 32'(nx), 32'd0);
         end
         if (pix_valid && (fv < 0)) fv = k;
         if (pix_valid && pix_ready) begin
            if (nx < 64) got_seq[nx] = pix_data;
            nx++;
            if (pix_last) nl++;
         end
         if (frame_done) begin
            dc = k;
            check("done_busy", 32'(busy), 32'd0);
            break;
         end
      end
      if (dc < 0) begin
         total++;
         bad++;
         $display("FAIL frame_timeout: no frame_done within 400 cycles");
      end
   endtask

   task automatic check_seq(input string tag);
      for (int i = 0; i < W * H; i++) check(tag, 32'(got_seq[i]), 32'(lit_seq[i]));
   endtask

   initial begin
      int fv, dc, nx, nl, n;
      // Reset held with start requested and noisy colour.
      rstn = 1'b0; frame_start = 1'b1; pix_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_x", 32'(paint_x), 32'd0);
      check("rst_y", 32'(paint_y), 32'd0);
      check("rst_data", 32'(pix_data), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_last", 32'(pix_last), 32'd0);
      check("rst_dbg_state", 32'(dbg_state), 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1; frame_start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(pix_valid), 32'd0);

      // Full rate.
      @(posedge clk); #1;
      run_frame(1'b0, 0, fv, dc, nx, nl);
      check("full_first_valid", 32'(fv), 32'd7);
      check("full_done_cycle", 32'(dc), 32'd19);
      check("full_count", 32'(nx), 32'd12);
      check("full_last_count", 32'(nl), 32'd1);
      check_seq("full_seq");

      // Backpressure window 5..30.
      @(posedge clk); #1;
      run_frame(1'b0, 1, fv, dc, nx, nl);
      check("bp_count", 32'(nx), 32'd12);
      check("bp_last_count", 32'(nl), 32'd1);
      check_seq("bp_seq");

      // Requests during SCAN and DRAIN ignored.
      @(posedge clk); #1;
      run_frame(1'b0, 3, fv, dc, nx, nl);
      check("ign_done_cycle", 32'(dc), 32'd19);
      check("ign_count", 32'(nx), 32'd12);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ign_no_restart", 32'(busy), 32'd0);

      // Back-to-back frame started in the frame_done cycle.
      @(posedge clk); #1;
      run_frame(1'b0, 0, fv, dc, nx, nl);
      frame_start = 1'b1;
      run_frame(1'b1, 0, fv, dc, nx, nl);
      check("b2b_done_cycle", 32'(dc), 32'd19);
      check("b2b_count", 32'(nx), 32'd12);
      check_seq("b2b_seq");

      // Reset after the 5th transfer.
      @(posedge clk); #1;
      frame_start = 1'b1; pix_ready = 1'b1;
      expect_frame();
      n = 0;
      for (int k = 1; (k <= 100) && (n < 5); k++) begin
         @(posedge clk); #1;
         frame_start = 1'b0;
         @(negedge clk);
         if (pix_valid && pix_ready) n++;
      end
      check("mid_pre_xfers", 32'(n), 32'd5);
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      check("mid_rst_valid", 32'(pix_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_x", 32'(paint_x), 32'd0);
      check("mid_rst_y", 32'(paint_y), 32'd0);
      repeat (2) @(posedge clk); #1;
      rstn = 1'b1;
      repeat (2) @(posedge clk); #1;
      run_frame(1'b0, 0, fv, dc, nx, nl);
      check("post_rst_first_valid", 32'(fv), 32'd7);
      check("post_rst_count", 32'(nx), 32'd12);
      check("post_rst_last_count", 32'(nl), 32'd1);
      check_seq("post_rst_seq");

      // Random backpressure frames.
      for (int f = 0; f < 20; f++) begin
         @(posedge clk); #1;
         run_frame(1'b0, 2, fv, dc, nx, nl);
         check("rnd_count", 32'(nx), 32'd12);
         check("rnd_last_count", 32'(nl), 32'd1);
         check_seq("rnd_seq");
      end

      @(posedge clk); #1;
      pix_ready = 1'b1;
      @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

endmodule
